thor2023_region_loader: RTL

THOR2023_REGION_LOADER -- requirements
Module: Thor2023_region_loader

---
 rtl/thor2023_region_loader_pkg.sv | 40 ++++
 rtl/thor2023_region_loader_timeout.sv | 28 ++
 rtl/thor2023_region_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/thor2023_region_loader_pkg.sv
// Shared types and constants for the boot-time region-table loader.
package Thor2023Mmupkg;

    typedef enum logic [3:0] {
        IDLE,
        UNLOCK,
        FETCH,
        WRITE,
        VERIFY,
        CHECK,
        NEXT,
        DONE,
        FAIL
    } loader_state_e;

    typedef enum logic [1:0] {
        FLD_PMT  = 2'd0,
        FLD_CTA  = 2'd1,
        FLD_AT   = 2'd2,
        FLD_LOCK = 2'd3
    } rgn_field_e;

    // ASCII lock / unlock keys written into the lock field
    localparam logic [31:0] LOCK = 32'h4C4F_434B;
    localparam logic [31:0] UNLK = 32'h554E_4C4B;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [31:0]  padr;
        logic [127:0] data1;
    } wb_cmd_request128_t;

    // Byte offset of (region, field) in both the boot table and the region table
    function automatic logic [31:0] tbl_offset(input logic [2:0] rgn, input logic [1:0] fld);
        return {23'd0, rgn, fld, 4'd0};
    endfunction

endpackage

// File: rtl/thor2023_region_loader_timeout.sv
// Down-counter bounding how long a boot-table read may wait for rd_ack.
module Thor2023_loader_timeout #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expire
);

    logic [CW-1:0] cnt;

    // Reload at the start of each fetch, count down while waiting
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= CW'(TIMEOUT);
        else if (dec && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    // Expires on the last permitted wait cycle, so the fetch lasts at most TIMEOUT cycles
    assign expire = (cnt <= CW'(1));

endmodule

// File: rtl/thor2023_region_loader.sv
// Copies region descriptors from the boot table into the region table,
// unlocking each region first and verifying its lock word afterwards.
module thor2023_region_loader
    import Thor2023Mmupkg::*;
#(
    parameter int unsigned NREGION    = 8,
    parameter logic [31:0] BOOT_BASE  = 32'hFFFC0000,
    parameter logic [31:0] RGN_BASE   = 32'hFEEF0000,
    parameter int unsigned TIMEOUT    = 255,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               rd_req,
    output logic [31:0]        rd_adr,
    input  logic               rd_ack,
    input  logic [127:0]       rd_dat,
    input  logic               rd_err,
    output logic               cs_rgn,
    output wb_cmd_request128_t wbs_req,
    input  logic [127:0]       dati,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         err_rgn
);

    localparam logic [2:0]  LAST_RGN = 3'(NREGION - 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 2);

    loader_state_e state, state_nx;
    rgn_field_e    fld, fld_nx;
    logic [2:0]    rgn, rgn_nx;
    logic [127:0]  word, word_nx;
    logic          done_nx, err_nx;
    logic [2:0]    err_rgn_nx;
    logic          auto_pend;
    logic          tmo_load, tmo_dec, tmo_expire;

    Thor2023_loader_timeout #(
        .TIMEOUT (TIMEOUT),
        .CW      (TMO_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (tmo_load),
        .dec    (tmo_dec),
        .expire (tmo_expire)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            fld       <= FLD_PMT;
            rgn       <= '0;
            word      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_rgn   <= '0;
            auto_pend <= AUTO_START;
        end else begin
            state     <= state_nx;
            fld       <= fld_nx;
            rgn       <= rgn_nx;
            word      <= word_nx;
            done      <= done_nx;
            err       <= err_nx;
            err_rgn   <= err_rgn_nx;
            auto_pend <= 1'b0;
        end
    end

    // Next-state logic and bus outputs
    always_comb begin
        state_nx   = state;
        fld_nx     = fld;
        rgn_nx     = rgn;
        word_nx    = word;
        done_nx    = done;
        err_nx     = err;
        err_rgn_nx = err_rgn;
        rd_req     = 1'b0;
        rd_adr     = '0;
        cs_rgn     = 1'b0;
        wbs_req    = '0;
        tmo_load   = 1'b0;
        tmo_dec    = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (start || auto_pend) begin
                    state_nx = UNLOCK;
                    rgn_nx   = '0;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            UNLOCK: begin
                cs_rgn        = 1'b1;
                wbs_req.cyc   = 1'b1;
                wbs_req.stb   = 1'b1;
                wbs_req.we    = 1'b1;
                wbs_req.padr  = RGN_BASE + tbl_offset(rgn, FLD_LOCK);
                wbs_req.data1 = {96'd0, UNLK};
                fld_nx        = FLD_PMT;
                tmo_load      = 1'b1;
                state_nx      = FETCH;
            end
            FETCH: begin
                rd_req  = 1'b1;
                rd_adr  = BOOT_BASE + tbl_offset(rgn, fld);
                tmo_dec = 1'b1;
                if (rd_ack) begin
                    if (rd_err) begin
                        state_nx = FAIL;
                    end else begin
                        word_nx  = rd_dat;
                        state_nx = WRITE;
                    end
                end else if (tmo_expire) begin
                    state_nx = FAIL;
                end
            end
            WRITE: begin
                cs_rgn        = 1'b1;
                wbs_req.cyc   = 1'b1;
                wbs_req.stb   = 1'b1;
                wbs_req.we    = 1'b1;
                wbs_req.padr  = RGN_BASE + tbl_offset(rgn, fld);
                wbs_req.data1 = word;
                if (fld == FLD_LOCK) begin
                    state_nx = VERIFY;
                end else begin
                    case (fld)
                        FLD_PMT: fld_nx = FLD_CTA;
                        FLD_CTA: fld_nx = FLD_AT;
                        default: fld_nx = FLD_LOCK;
                    endcase
                    tmo_load = 1'b1;
                    state_nx = FETCH;
                end
            end
            VERIFY: begin
                cs_rgn       = 1'b1;
                wbs_req.cyc  = 1'b1;
                wbs_req.stb  = 1'b1;
                wbs_req.padr = RGN_BASE + tbl_offset(rgn, FLD_LOCK);
                state_nx     = CHECK;
            end
            CHECK: begin
                // word still holds the lock field fetched last for this region
                state_nx = (dati == word) ? NEXT : FAIL;
            end
            NEXT: begin
                if (rgn == LAST_RGN) begin
                    state_nx = DONE;
                end else begin
                    rgn_nx   = rgn + 3'd1;
                    state_nx = UNLOCK;
                end
            end
            DONE: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            FAIL: begin
                err_nx     = 1'b1;
                err_rgn_nx = rgn;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
